// File: rtl/core_boot_seq.sv
// Boot/reset sequencer for the PULPino core: releases peripheral reset, then core reset,
// then enables instruction fetch; a debounced soft-reset button and a halt switch steer it.
module core_boot_seq #(
  parameter int          RESET_HOLD_CYCLES    = 256,
  parameter int          PERIPH_SETTLE_CYCLES = 16,
  parameter int          FETCH_DELAY_CYCLES   = 64,
  parameter int          DEBOUNCE_CYCLES      = 1000,
  parameter logic [31:0] BOOT_ADDR            = 32'h00008000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        soft_rst_btn_n,
  input  logic        halt_req,
  output logic        periph_rst_n,
  output logic        core_rst_n,
  output logic        fetch_enable_o,
  output logic [31:0] boot_addr_o,
  output logic        boot_done,
  output logic [2:0]  state_o
);

  localparam int MAX_AB  = (RESET_HOLD_CYCLES > PERIPH_SETTLE_CYCLES) ? RESET_HOLD_CYCLES : PERIPH_SETTLE_CYCLES;
  localparam int MAX_CD  = (FETCH_DELAY_CYCLES > DEBOUNCE_CYCLES) ? FETCH_DELAY_CYCLES : DEBOUNCE_CYCLES;
  localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(PERIPH_SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] FETCH_LAST  = CNT_W'(FETCH_DELAY_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_RESET_HOLD  = 3'd0,
    ST_PERIPH_WAIT = 3'd1,
    ST_CORE_WAIT   = 3'd2,
    ST_RUN         = 3'd3,
    ST_HALT        = 3'd4
  } state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt, cnt_next;

  logic             halt_s1, halt_s2;
  logic             btn_s1, btn_s2;
  logic [DB_W-1:0]  db_cnt;
  logic             db_armed;
  logic             press;
  logic             press_fire;

  logic             periph_rst_next, core_rst_next, fetch_next, done_next;

  assign boot_addr_o = BOOT_ADDR;

  // Synchronisers for the two asynchronous board inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt_s1 <= 1'b0;
      halt_s2 <= 1'b0;
      btn_s1  <= 1'b0;
      btn_s2  <= 1'b0;
    end else begin
      halt_s1 <= halt_req;
      halt_s2 <= halt_s1;
      btn_s1  <= soft_rst_btn_n;
      btn_s2  <= btn_s1;
    end
  end

  // Debouncer stays disarmed out of reset until it has seen the button released,
  // so the cleared synchroniser cannot fake a press.
  assign press_fire = db_armed && !btn_s2 && (db_cnt == DB_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt   <= '0;
      db_armed <= 1'b0;
      press    <= 1'b0;
    end else begin
      press <= press_fire;
      if (btn_s2) begin
        db_cnt   <= '0;
        db_armed <= 1'b1;
      end else begin
        if (db_cnt != DB_LAST) begin
          db_cnt <= db_cnt + 1'b1;
        end
        if (press_fire) begin
          db_armed <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    next_state = state;
    cnt_next   = cnt + 1'b1;
    case (state)
      ST_RESET_HOLD: begin
        if (press) begin
          cnt_next = '0;
        end else if (cnt == HOLD_LAST) begin
          next_state = ST_PERIPH_WAIT;
        end
      end
      ST_PERIPH_WAIT: begin
        if (press) begin
          next_state = ST_RESET_HOLD;
        end else if (cnt == SETTLE_LAST) begin
          next_state = ST_CORE_WAIT;
        end
      end
      ST_CORE_WAIT: begin
        if (press) begin
          next_state = ST_RESET_HOLD;
        end else if (cnt == FETCH_LAST) begin
          next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        cnt_next = cnt;
        if (press) begin
          next_state = ST_RESET_HOLD;
        end else if (halt_s2) begin
          next_state = ST_HALT;
        end
      end
      ST_HALT: begin
        cnt_next = cnt;
        if (press) begin
          next_state = ST_RESET_HOLD;
        end else if (!halt_s2) begin
          next_state = ST_RUN;
        end
      end
      default: begin
        next_state = ST_RESET_HOLD;
      end
    endcase
    if (next_state != state) begin
      cnt_next = '0;
    end
  end

  // Outputs are decoded from next_state so they flip on the same edge as the state.
  always_comb begin
    periph_rst_next = (next_state != ST_RESET_HOLD);
    core_rst_next   = (next_state == ST_CORE_WAIT) || (next_state == ST_RUN) || (next_state == ST_HALT);
    fetch_next      = (next_state == ST_RUN);
    done_next       = (next_state == ST_RUN) || (next_state == ST_HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_RESET_HOLD;
      cnt            <= '0;
      periph_rst_n   <= 1'b0;
      core_rst_n     <= 1'b0;
      fetch_enable_o <= 1'b0;
      boot_done      <= 1'b0;
    end else begin
      state          <= next_state;
      cnt            <= cnt_next;
      periph_rst_n   <= periph_rst_next;
      core_rst_n     <= core_rst_next;
      fetch_enable_o <= fetch_next;
      boot_done      <= done_next;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_core_boot_seq.sv
// Directed bench for core_boot_seq with short cycle parameters (8/4/6, debounce 5).
module tb_core_boot_seq;

  logic        clk;
  logic        rst_n;
  logic        soft_rst_btn_n;
  logic        halt_req;
  logic        periph_rst_n;
  logic        core_rst_n;
  logic        fetch_enable_o;
  logic [31:0] boot_addr_o;
  logic        boot_done;
  logic [2:0]  state_o;

  int total = 0;
  int bad   = 0;

  core_boot_seq #(
    .RESET_HOLD_CYCLES   (8),
    .PERIPH_SETTLE_CYCLES(4),
    .FETCH_DELAY_CYCLES  (6),
    .DEBOUNCE_CYCLES     (5),
    .BOOT_ADDR           (32'h00008000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .soft_rst_btn_n(soft_rst_btn_n),
    .halt_req      (halt_req),
    .periph_rst_n  (periph_rst_n),
    .core_rst_n    (core_rst_n),
    .fetch_enable_o(fetch_enable_o),
    .boot_addr_o   (boot_addr_o),
    .boot_done     (boot_done),
    .state_o       (state_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [2:0] st, input logic pr, input logic cr,
                         input logic fe, input logic bd);
    chk({tag, " state"}, {29'd0, state_o}, {29'd0, st});
    chk({tag, " periph_rst_n"}, {31'd0, periph_rst_n}, {31'd0, pr});
    chk({tag, " core_rst_n"}, {31'd0, core_rst_n}, {31'd0, cr});
    chk({tag, " fetch_enable"}, {31'd0, fetch_enable_o}, {31'd0, fe});
    chk({tag, " boot_done"}, {31'd0, boot_done}, {31'd0, bd});
  endtask

  // Walks 18 edges from a reference edge 0, checking every output at each edge.
  // The button is released after edge rel (0 = leave it alone).
  task automatic check_boot(input string name, input int rel);
    logic [2:0] exp_st;
    for (int e = 1; e <= 18; e++) begin
      step(1);
      if (e == rel) soft_rst_btn_n = 1'b1;
      exp_st = (e < 8) ? 3'd0 : (e < 12) ? 3'd1 : (e < 18) ? 3'd2 : 3'd3;
      chk_all($sformatf("%s e%0d", name, e), exp_st, e >= 8, e >= 12, e >= 18, e >= 18);
    end
    chk({name, " boot_addr"}, boot_addr_o, 32'h00008000);
  endtask

  initial begin
    rst_n          = 1'b0;
    soft_rst_btn_n = 1'b1;
    halt_req       = 1'b0;

    // Power-up
    step(5);
    chk_all("in_reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("in_reset boot_addr", boot_addr_o, 32'h00008000);
    rst_n = 1'b1;
    check_boot("powerup", 0);

    // Halt for 10 cycles while running
    halt_req = 1'b1;
    step(2);
    chk_all("halt k+2", 3'd3, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1);
    chk_all("halt k+3", 3'd4, 1'b1, 1'b1, 1'b0, 1'b1);
    step(7);
    halt_req = 1'b0;
    step(2);
    chk_all("unhalt k+2", 3'd4, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1);
    chk_all("unhalt k+3", 3'd3, 1'b1, 1'b1, 1'b1, 1'b1);

    // 3-cycle glitch must be filtered out
    soft_rst_btn_n = 1'b0;
    step(3);
    soft_rst_btn_n = 1'b1;
    step(10);
    chk_all("glitch", 3'd3, 1'b1, 1'b1, 1'b1, 1'b1);

    // 20-cycle hold: one press, one reset sequence
    soft_rst_btn_n = 1'b0;
    step(7);
    chk_all("press t+7", 3'd3, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1);
    chk_all("press t+8", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_boot("press", 12);
    step(20);
    chk_all("press settled", 3'd3, 1'b1, 1'b1, 1'b1, 1'b1);

    // Press and halt arriving together during CORE_WAIT
    soft_rst_btn_n = 1'b0;
    step(8);
    chk_all("sim ref", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(2);
    soft_rst_btn_n = 1'b1;
    step(5);
    chk_all("sim e7", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    soft_rst_btn_n = 1'b0;
    step(5);
    chk_all("sim e12", 3'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    halt_req = 1'b1;
    step(2);
    chk_all("sim e14", 3'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1);
    chk_all("sim e15", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_boot("sim", 3);
    step(1);
    chk_all("sim halt after run", 3'd4, 1'b1, 1'b1, 1'b0, 1'b1);
    halt_req = 1'b0;
    step(3);
    chk_all("sim unhalt", 3'd3, 1'b1, 1'b1, 1'b1, 1'b1);

    // Asynchronous reset during PERIPH_WAIT
    soft_rst_btn_n = 1'b0;
    step(8);
    chk_all("async ref", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1);
    soft_rst_btn_n = 1'b1;
    step(8);
    chk_all("async e9", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    #4;
    rst_n = 1'b0;
    #1;
    chk_all("async immediate", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1);
    chk_all("async held", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    check_boot("after_async", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
